// File: rtl/alarm_ring.sv
// alarm_ring
//   Compares the alarm time digits with the running clock time once per
//   minute and drives the buzzer. Handles the stop/snooze buttons, the ring
//   timeout and the snooze countdown.
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   tick_1hz              : one-clk pulse per second
//   minute_tick           : one-clk pulse when t3..t0 change to a new minute
//   t0..t3                : current time BCD (min units, min tens, hr units, hr tens)
//   al0..al3              : alarm time BCD, same digit order
//   alarm_en              : alarm armed (level)
//   bstop, bsnooze        : raw buttons, asynchronous to clk
//   ringing, snoozed      : state flags
//   buzzer                : square-wave tone while ringing, else 0
module alarm_ring #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int TONE_DIV   = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       minute_tick,
  input  logic [3:0] t0,
  input  logic [3:0] t1,
  input  logic [3:0] t2,
  input  logic [3:0] t3,
  input  logic [3:0] al0,
  input  logic [3:0] al1,
  input  logic [3:0] al2,
  input  logic [3:0] al3,
  input  logic       alarm_en,
  input  logic       bstop,
  input  logic       bsnooze,
  output logic       ringing,
  output logic       snoozed,
  output logic       buzzer
);

  localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam int SW = $clog2(SNOOZE_MIN + 1);
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
  localparam logic [SW-1:0] SNZ_INIT  = SW'(SNOOZE_MIN);
  localparam logic [SW-1:0] SNZ_ONE   = SW'(1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RING   = 2'd1;
  localparam logic [1:0] S_SNOOZE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic [TW-1:0] tone_cnt_q, tone_cnt_d;
  logic          tone_q, tone_d;

  // Two-flop synchronizer chain per button, plus the previous synchronized
  // value for rising-edge detection.
  logic [1:0] stop_sync_q, snz_sync_q;
  logic       stop_prev_q, snz_prev_q;
  logic       stop_edge, snooze_edge;
  logic       match;

  assign stop_edge   = stop_sync_q[1] & ~stop_prev_q;
  assign snooze_edge = snz_sync_q[1] & ~snz_prev_q;

  assign match = alarm_en & minute_tick &
                 (t3 == al3) & (t2 == al2) & (t1 == al1) & (t0 == al0);

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;

    if (state_q == S_RING) begin
      if (tone_cnt_q == TONE_LAST) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 1'b1;
      end
    end

    // Disarming wins over every other event in the same cycle.
    if (!alarm_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (match) begin
            state_d    = S_RING;
            ring_cnt_d = '0;
            tone_cnt_d = '0;
            tone_d     = 1'b0;
          end
        end
        S_RING: begin
          if (stop_edge) begin
            state_d = S_IDLE;
          end else if (snooze_edge) begin
            state_d   = S_SNOOZE;
            snz_cnt_d = SNZ_INIT;
          end else if (tick_1hz) begin
            if (ring_cnt_q == RING_LAST) state_d = S_IDLE;
            else                         ring_cnt_d = ring_cnt_q + 1'b1;
          end
        end
        S_SNOOZE: begin
          if (stop_edge) begin
            state_d = S_IDLE;
          end else if (minute_tick) begin
            if (snz_cnt_q == SNZ_ONE) begin
              state_d    = S_RING;
              ring_cnt_d = '0;
              tone_cnt_d = '0;
              tone_d     = 1'b0;
            end else begin
              snz_cnt_d = snz_cnt_q - 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ring_cnt_q  <= '0;
      snz_cnt_q   <= '0;
      tone_cnt_q  <= '0;
      tone_q      <= 1'b0;
      stop_sync_q <= '0;
      snz_sync_q  <= '0;
      stop_prev_q <= 1'b0;
      snz_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ring_cnt_q  <= ring_cnt_d;
      snz_cnt_q   <= snz_cnt_d;
      tone_cnt_q  <= tone_cnt_d;
      tone_q      <= tone_d;
      stop_sync_q <= {stop_sync_q[0], bstop};
      snz_sync_q  <= {snz_sync_q[0], bsnooze};
      stop_prev_q <= stop_sync_q[1];
      snz_prev_q  <= snz_sync_q[1];
    end
  end

  assign ringing = (state_q == S_RING);
  assign snoozed = (state_q == S_SNOOZE);
  // tone_q may hold a stale 1 after leaving RING; gate it off here.
  assign buzzer  = ringing & tone_q;

endmodule

// File: tb/tb_alarm_ring.sv
module tb_alarm_ring;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, minute_tick;
  logic [3:0] t0, t1, t2, t3;
  logic [3:0] al0, al1, al2, al3;
  logic       alarm_en, bstop, bsnooze;
  logic       ringing, snoozed, buzzer;

  alarm_ring #(.RING_SECS(4), .SNOOZE_MIN(2), .TONE_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .minute_tick(minute_tick),
    .t0(t0), .t1(t1), .t2(t2), .t3(t3),
    .al0(al0), .al1(al1), .al2(al2), .al3(al3),
    .alarm_en(alarm_en), .bstop(bstop), .bsnooze(bsnooze),
    .ringing(ringing), .snoozed(snoozed), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  // Expected {ringing, snoozed, buzzer}
  localparam logic [2:0] IDL = 3'b000;
  localparam logic [2:0] R0  = 3'b100;
  localparam logic [2:0] R1  = 3'b101;
  localparam logic [2:0] SNZ = 3'b010;

  typedef struct {
    logic       tick;
    logic       mt;
    logic       stop;
    logic       snz;
    logic [2:0] exp;
  } vec_t;

  typedef struct {
    logic [2:0] exp;
    string      name;
  } sb_t;

  sb_t  sbq[$];
  vec_t tbl[12];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: ring/snz/buz got %b required %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic settime(input logic [3:0] h1, h0, m1, m0);
    t3 = h1; t2 = h0; t1 = m1; t0 = m0;
  endtask

  // One clock: drive inputs, queue the expectation, compare after the edge.
  task automatic cyc(input logic tk, mt, st, sn, input logic [2:0] exp, input string nm);
    sb_t e;
    tick_1hz = tk; minute_tick = mt; bstop = st; bsnooze = sn;
    e.exp = exp; e.name = nm;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, 3'b111, 3'b000);
    end else begin
      e = sbq.pop_front();
      chk(e.name, {ringing, snoozed, buzzer}, e.exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1 table: ring at 07:30, tone every 3 clk, stop after 4 ticks
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, R0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, R0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, R0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, R1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, R1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, R1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, R0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, R0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, R0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, R1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, IDL};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, IDL};

    rst_n = 1'b0;
    tick_1hz = 0; minute_tick = 0; bstop = 0; bsnooze = 0;
    alarm_en = 1'b1;
    al3 = 4'd0; al2 = 4'd7; al1 = 4'd3; al0 = 4'd0;
    settime(4'd0, 4'd7, 4'd2, 4'd9);
    #12;
    chk("reset", {ringing, snoozed, buzzer}, IDL);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1
    settime(4'd0, 4'd7, 4'd3, 4'd0);
    for (int i = 0; i < 12; i++)
      cyc(tbl[i].tick, tbl[i].mt, tbl[i].stop, tbl[i].snz, tbl[i].exp,
          $sformatf("t1_row%0d", i));

    // Test 2: snooze, re-ring after 2 minutes, stop, no re-ring at 07:33
    cyc(0, 1, 0, 0, R0, "t2_ring");
    cyc(0, 0, 0, 0, R0, "t2_r1");
    cyc(0, 0, 0, 0, R0, "t2_r2");
    cyc(0, 0, 0, 0, R1, "t2_r3");
    cyc(0, 0, 0, 1, R1, "t2_snz_a");
    cyc(0, 0, 0, 0, R1, "t2_snz_b");
    cyc(0, 0, 0, 0, SNZ, "t2_snoozed");
    settime(4'd0, 4'd7, 4'd3, 4'd1);
    cyc(0, 1, 0, 0, SNZ, "t2_min1");
    cyc(0, 0, 0, 0, SNZ, "t2_hold");
    settime(4'd0, 4'd7, 4'd3, 4'd2);
    cyc(0, 1, 0, 0, R0, "t2_rering");
    cyc(0, 0, 1, 0, R0, "t2_stop_a");
    cyc(0, 0, 0, 0, R0, "t2_stop_b");
    cyc(0, 0, 0, 0, IDL, "t2_stopped");
    settime(4'd0, 4'd7, 4'd3, 4'd3);
    cyc(0, 1, 0, 0, IDL, "t2_no_rering");

    // Test 3: stop and snooze together -> stop wins
    settime(4'd0, 4'd7, 4'd3, 4'd0);
    cyc(0, 1, 0, 0, R0, "t3_ring");
    cyc(0, 0, 1, 1, R0, "t3_both_a");
    cyc(0, 0, 0, 0, R0, "t3_both_b");
    cyc(0, 0, 0, 0, IDL, "t3_idle");
    cyc(0, 0, 0, 0, IDL, "t3_no_snooze");

    // Test 4: disarm behaviour
    alarm_en = 1'b0;
    cyc(0, 1, 0, 0, IDL, "t4_disarmed");
    alarm_en = 1'b1;
    cyc(0, 1, 0, 0, R0, "t4_ring");
    alarm_en = 1'b0;
    cyc(0, 0, 0, 0, IDL, "t4_drop_ring");
    alarm_en = 1'b1;
    cyc(0, 1, 0, 0, R0, "t4_ring2");
    cyc(0, 0, 0, 1, R0, "t4_snz_a");
    cyc(0, 0, 0, 0, R0, "t4_snz_b");
    cyc(0, 0, 0, 0, SNZ, "t4_snoozed");
    alarm_en = 1'b0;
    cyc(0, 0, 0, 0, IDL, "t4_drop_snz");
    alarm_en = 1'b1;
    cyc(0, 0, 0, 0, IDL, "t4_stays_idle");

    // Test 5: no minute_tick -> no ring; held snooze -> single entry
    for (int i = 0; i < 20; i++)
      cyc(0, 0, 0, 0, IDL, $sformatf("t5_no_mt%0d", i));
    cyc(0, 1, 0, 0, R0, "t5_ring");
    cyc(0, 0, 0, 1, R0, "t5_held1");
    cyc(0, 0, 0, 1, R0, "t5_held2");
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, 1, SNZ, $sformatf("t5_held_snz%0d", i));
    settime(4'd0, 4'd7, 4'd3, 4'd1);
    cyc(0, 1, 0, 1, SNZ, "t5_min1");
    settime(4'd0, 4'd7, 4'd3, 4'd2);
    cyc(0, 1, 0, 1, R0, "t5_rering");
    cyc(0, 0, 0, 1, R0, "t5_held_r1");
    cyc(0, 0, 0, 1, R0, "t5_held_r2");
    cyc(0, 0, 0, 1, R1, "t5_held_r3");
    cyc(0, 0, 1, 0, R1, "t5_stop_a");
    cyc(0, 0, 0, 0, R1, "t5_stop_b");
    cyc(0, 0, 0, 0, IDL, "t5_stopped");

    // Test 6: async reset mid-ring
    settime(4'd0, 4'd7, 4'd3, 4'd0);
    cyc(0, 1, 0, 0, R0, "t6_ring");
    cyc(0, 0, 0, 0, R0, "t6_r1");
    cyc(0, 0, 0, 0, R0, "t6_r2");
    cyc(0, 0, 0, 0, R1, "t6_r3");
    #3 rst_n = 1'b0;
    #1 chk("t6_async_reset", {ringing, snoozed, buzzer}, IDL);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_after_release", {ringing, snoozed, buzzer}, IDL);
    cyc(0, 0, 0, 0, IDL, "t6_no_resume1");
    cyc(1, 0, 0, 0, IDL, "t6_no_resume2");
    cyc(0, 0, 0, 0, IDL, "t6_no_resume3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
